// File: rtl/irrig_mux_arbiter.sv
// Two-source round-robin arbiter for the shared 4-bit irrigation valve bus, with minimum grant
// hold and an all-closed guard interval between owners. Optional grant limit: IRRIG_ARB_TIMEOUT_EN.
module irrig_mux_arbiter #(
    parameter int unsigned MIN_HOLD     = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned MAX_GRANT    = 200,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       sel,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] GUARD_C   = CNT_W'(GUARD_CYCLES);
    localparam bit               NO_GUARD  = (GUARD_CYCLES == 32'd0);

    // Counters must be able to represent every configured limit without wrapping.
    if ((MIN_HOLD >= (32'd1 << CNT_W)) || (GUARD_CYCLES >= (32'd1 << CNT_W)) ||
        (MAX_GRANT >= (32'd1 << CNT_W)) || (MIN_HOLD < 32'd1)) begin : g_bad_cfg
        $error("irrig_mux_arbiter: illegal MIN_HOLD/GUARD_CYCLES/MAX_GRANT for CNT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;    // current owner in GRANT, last owner otherwise
    logic             sel_q, sel_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             valid_q, valid_d;
    logic [3:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       lock_q, lock_d;

    logic [1:0]       req_m_s;
    logic             win_s;
    logic             own_req_s;
    logic [3:0]       own_data_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             hold_met_s;
    logic             limit_hit_s;
    logic             rel_normal_s;
    logic             rel_forced_s;

    assign req_m_s      = {req1, req0} & ~lock_q;
    assign win_s        = (req_m_s == 2'b11) ? ~owner_q : req_m_s[1];
    assign own_req_s    = owner_q ? req1 : req0;
    assign own_data_s   = owner_q ? data1 : data0;
    assign cnt_inc_s    = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
    assign hold_met_s   = (cnt_q >= HOLD_C);
`ifdef IRRIG_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_GRANT);
    assign limit_hit_s  = (cnt_q >= MAX_C);
`else
    assign limit_hit_s  = 1'b0;
`endif
    assign rel_normal_s = ~own_req_s & hold_met_s;
    assign rel_forced_s = own_req_s & limit_hit_s;

    // Next-state and next-output decode for the IDLE/GRANT/GUARD sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        sel_d     = sel_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        valid_d   = 1'b0;
        data_d    = 4'b0000;
        timeout_d = 1'b0;
        lock_d    = lock_q & {req1, req0};

        case (state_q)
            ST_IDLE: begin
                if (req_m_s != 2'b00) begin
                    state_d = ST_GRANT;
                    owner_d = win_s;
                    sel_d   = win_s;
                    gnt0_d  = ~win_s;
                    gnt1_d  = win_s;
                    cnt_d   = CNT_ONE;
                end else begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (rel_normal_s || rel_forced_s) begin
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    cnt_d     = CNT_ONE;
                    state_d   = NO_GUARD ? ST_IDLE : ST_GUARD;
                    timeout_d = rel_forced_s;
                    if (rel_forced_s) begin
                        lock_d = lock_d | (owner_q ? 2'b10 : 2'b01);
                    end else begin
                        lock_d = lock_d;
                    end
                end else begin
                    valid_d = 1'b1;
                    data_d  = own_data_s;
                    cnt_d   = cnt_inc_s;
                end
            end
            ST_GUARD: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                if (cnt_q >= GUARD_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset closes the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= 1'b1;
            sel_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            lock_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            sel_q     <= sel_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            lock_q    <= lock_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_irrig_mux_arbiter.sv
// Self-checking bench for irrig_mux_arbiter: directed vector table, hand sequences for reset,
// alternation and (with IRRIG_ARB_TIMEOUT_EN) the grant limit, then random traffic vs a model.
module tb_irrig_mux_arbiter;

    localparam int MIN_HOLD = 4;
    localparam int GUARD    = 2;
    localparam int MAXG     = 20;
`ifdef IRRIG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] data0 = 4'h0, data1 = 4'h0;
    logic       gnt0, gnt1, sel, out_valid, busy, timeout;
    logic [3:0] out_data;

    irrig_mux_arbiter #(.MIN_HOLD(MIN_HOLD), .GUARD_CYCLES(GUARD), .MAX_GRANT(MAXG), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       r0, r1;
        logic [3:0] d0, d1;
        logic [9:0] exp;   // {gnt0,gnt1,sel,valid,data[3:0],busy,timeout}
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(logic r0, logic r1, logic [3:0] d0, logic [3:0] d1,
                                logic g0, logic g1, logic s, logic v, logic [3:0] od, logic b);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1;
        t.exp = {g0, g1, s, v, od, b, 1'b0};
        return t;
    endfunction

    function automatic logic [9:0] outs();
        return {gnt0, gnt1, sel, out_valid, out_data, busy, timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_own, m_age, m_closed, m_last;
    bit m_lock[2];
    logic e_g0, e_g1, e_sel, e_v, e_b, e_to;
    logic [3:0] e_d;

    task automatic model_reset();
        m_own = -1; m_age = 0; m_closed = 0; m_last = 1;
        m_lock[0] = 0; m_lock[1] = 0;
        e_g0 = 0; e_g1 = 0; e_sel = 0; e_v = 0; e_d = 0; e_b = 0; e_to = 0;
    endtask

    // Predicts the outputs after the next rising edge given the inputs held across it.
    task automatic model_step(input bit r0, input bit r1, input logic [3:0] d0, input logic [3:0] d1);
        bit r[2];
        logic [3:0] d[2];
        int forced_src;
        r[0] = r0; r[1] = r1; d[0] = d0; d[1] = d1;
        forced_src = -1;
        e_to = 0;
        if (m_own >= 0) begin
            if ((!r[m_own] && m_age >= MIN_HOLD) || (TO_EN && r[m_own] && m_age >= MAXG)) begin
                if (r[m_own]) begin e_to = 1; forced_src = m_own; end
                m_last = m_own; m_own = -1; m_closed = GUARD;
                e_g0 = 0; e_g1 = 0; e_v = 0; e_d = 0; e_b = (GUARD > 0);
            end else begin
                e_v = 1; e_d = d[m_own];
                if (m_age < 255) m_age++;
            end
        end else if (m_closed > 0) begin
            m_closed--;
            e_b = (m_closed > 0);
        end else begin
            bit a0, a1;
            a0 = r[0] && !m_lock[0];
            a1 = r[1] && !m_lock[1];
            if (a0 || a1) begin
                m_own = (a0 && a1) ? 1 - m_last : (a1 ? 1 : 0);
                m_age = 1;
                e_g0 = (m_own == 0); e_g1 = (m_own == 1); e_sel = m_own[0];
                e_v = 0; e_d = 0; e_b = 1;
            end else begin
                e_b = 0;
            end
        end
        for (int i = 0; i < 2; i++) m_lock[i] = m_lock[i] && r[i];
        if (forced_src >= 0) m_lock[forced_src] = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 10'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // Directed table: single grant of 0 with data A, a 1-cycle req1 pulse, then a tie.
        vecs.push_back(mk(1, 0, 4'hA, 4'h0, 1, 0, 0, 0, 4'h0, 1));
        for (int i = 0; i < 9; i++) vecs.push_back(mk(1, 0, 4'hA, 4'h0, 1, 0, 0, 1, 4'hA, 1));
        vecs.push_back(mk(0, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h0, 1));
        vecs.push_back(mk(0, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h0, 1));
        vecs.push_back(mk(0, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 4'h0, 4'h5, 0, 1, 1, 0, 4'h0, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 4'h0, 4'h5, 0, 1, 1, 1, 4'h5, 1));
        vecs.push_back(mk(0, 0, 4'h0, 4'h5, 0, 0, 1, 0, 4'h0, 1));
        vecs.push_back(mk(0, 0, 4'h0, 4'h5, 0, 0, 1, 0, 4'h0, 1));
        vecs.push_back(mk(0, 0, 4'h0, 4'h5, 0, 0, 1, 0, 4'h0, 0));
        vecs.push_back(mk(1, 1, 4'h3, 4'hC, 1, 0, 0, 0, 4'h0, 1));
        vecs.push_back(mk(1, 1, 4'h3, 4'hC, 1, 0, 0, 1, 4'h3, 1));

        do_reset();
        foreach (vecs[i]) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; data0 = vecs[i].d0; data1 = vecs[i].d1;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Async reset mid-grant with F on the bus; restart must give source 0 the tie.
        data0 = 4'hF;
        @(posedge clk); #1;
        check("pre_rst_data", {out_valid, out_data}, {1'b1, 4'hF});
        #2 rst_n = 1'b0;
        #1 check("async_rst_clear", outs(), 10'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("restart_tie_gnt0", {gnt0, gnt1, sel}, 3'b100);

        // Both sources keep re-requesting: ownership must alternate 0,1,0.
        begin
            int order[$];
            int held;
            logic p0, p1;
            do_reset();
            held = 0; p0 = 0; p1 = 0;
            req0 = 1; req1 = 1;
            for (int c = 0; c < 300 && order.size() < 3; c++) begin
                @(posedge clk); #1;
                if (gnt0 && !p0) order.push_back(0);
                if (gnt1 && !p1) order.push_back(1);
                p0 = gnt0; p1 = gnt1;
                held = (gnt0 || gnt1) ? held + 1 : 0;
                req0 = !(gnt0 && held >= 6);
                req1 = !(gnt1 && held >= 6);
            end
            check("alt_count", order.size(), 3);
            if (order.size() == 3) check("alt_order", {order[0][1:0], order[1][1:0], order[2][1:0]}, 6'b00_01_00);
        end

`ifdef IRRIG_ARB_TIMEOUT_EN
        // Grant limit: req0 held 50 cycles is cut at MAX_GRANT and locked out until it drops.
        begin
            int g_cyc, to_cyc, regrants;
            logic p0;
            do_reset();
            g_cyc = 0; to_cyc = 0; regrants = 0; p0 = 0;
            req0 = 1;
            for (int c = 0; c < 50; c++) begin
                @(posedge clk); #1;
                if (gnt0) g_cyc++;
                if (timeout) to_cyc++;
                if (gnt0 && !p0 && c > 0) regrants++;
                p0 = gnt0;
            end
            check("to_grant_len", g_cyc, MAXG);
            check("to_pulse_len", to_cyc, 1);
            check("to_no_regrant", regrants, 0);
            req0 = 0;
            @(posedge clk); #1;
            req0 = 1;
            g_cyc = 0;
            for (int c = 0; c < 6 && g_cyc == 0; c++) begin
                @(posedge clk); #1;
                if (gnt0) g_cyc = 1;
            end
            check("to_regrant_after_low", g_cyc, 1);
        end
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            data0 = 4'($urandom);
            data1 = 4'($urandom);
            model_step(req0, req1, data0, data1);
            @(posedge clk); #1;
            check("rand_outs", outs(), {e_g0, e_g1, e_sel, e_v, e_d, e_b, e_to});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
